alu_uop_issue: RTL and testbench
================================

ALU_UOP_ISSUE -- requirements
Module: alu_uop_issue

Interface
REQ-001 SHALL provide parameter NREG, default 16, meaning number of 32-bit general registers (index width 4).
REQ-002 SHALL provide ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide: req_valid  in  1  micro-op offered.
REQ-005 SHALL provide: req_ready  out  1  micro-op accepted when req_valid&req_ready at a rising edge.
REQ-006 SHALL provide: req_op  in  5  micro-op code, same encoding the ALU consumes.
REQ-007 SHALL provide: req_rn  in  4  destination / source-A register index.
REQ-008 SHALL provide: req_rm  in  4  source-B register index.
REQ-009 SHALL provide: req_useimm  in  1  select req_imm instead of register rm for source B.
REQ-010 SHALL provide: req_imm  in  32  immediate operand.
REQ-011 SHALL provide: alu_op  out  5,  alu_srca  out  32,  alu_srcb  out  32,  alu_sri  out  4  drive to ALU.
REQ-012 SHALL provide: alu_dst  in  32,  alu_sro  in  4  combinational ALU results.
REQ-013 SHALL provide: sr  out  4  architectural status register; bit 0 is T.
REQ-014 SHALL provide: done  out  1  one-cycle pulse at writeback.
REQ-015 SHALL provide: err  out  1  sticky illegal-opcode flag.
REQ-016 SHALL provide: dbg_idx  in  4,  dbg_data  out  32  combinational register readback.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; one micro-op in flight, no overlap.
REQ-018 req_ready SHALL be 1 only in IDLE; an accepted request moves FSM to EXEC at that edge.
REQ-019 On accept SHALL latch op, rn, srca=R[rn], srcb=(useimm ? imm : R[rm]), sri=sr.
REQ-020 alu_op/alu_srca/alu_srcb/alu_sri SHALL be registered, held stable through EXEC and WB, and be 0 in IDLE.
REQ-021 In WB SHALL sample alu_dst/alu_sro, perform writeback at the WB->IDLE edge, and assert done for exactly the WB cycle.
REQ-022 Latency: accept at edge N -> done high during cycle after edge N+1 -> register/sr updated at edge N+2; req_ready high again after edge N+2.
REQ-023 Ops 0x01-0x09 and 0x14-0x17 SHALL write R[rn]=alu_dst and sr=alu_sro.
REQ-024 Ops 0x18 and 0x1B-0x1F SHALL write sr=alu_sro only; R[rn] unchanged.
REQ-025 Op 0x00 SHALL complete (done pulse) with no register or sr change.
REQ-026 Ops 0x0A-0x13, 0x19, 0x1A SHALL be treated as 0x00 for writeback, still pulse done, and set err=1 at the WB->IDLE edge.
REQ-027 err SHALL clear only on reset.
REQ-028 rn==rm SHALL read both operands from the same pre-writeback value.
REQ-029 A request with req_valid high outside IDLE SHALL be ignored; requester holds it until accepted.
REQ-030 dbg_data SHALL equal R[dbg_idx] current contents; a write to that register shows at the next cycle.
REQ-031 Arithmetic SHALL be 32-bit modulo; no width extension beyond ALU outputs.

Reset
REQ-032 rst_n low SHALL asynchronously force FSM=IDLE, all registers R0-R15=0, sr=0, err=0, done=0, alu_* outputs=0.
REQ-033 req_ready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-034 Reset during EXEC or WB SHALL abort the micro-op with no writeback and no done pulse.

Verification
REQ-035 R1=5, R2=7, issue op 0x01 rn=1 rm=2 -> done 2 cycles after accept, R1=12, R2=7, req_ready re-high.
REQ-036 sr=0x1, R3=0xFFFFFFFF, issue op 0x14 rn=3 useimm imm=0 -> alu_sri=0x1, R3=0x00000000, sr=alu_sro.
REQ-037 R4=9, issue op 0x1B rn=4 useimm imm=9 -> sr[0]=1, R4 still 9; repeat imm=8 -> sr[0]=0.
REQ-038 Two back-to-back requests with req_valid held high -> second accepted exactly 3 cycles after first, results in order.
REQ-039 Issue op 0x0C -> done pulse, no register/sr change, err=1 and stays 1 across later legal ops.
REQ-040 Assert rst_n low during EXEC of op 0x01 -> no done, all registers/sr=0, req_ready=1 after release.

Source files
------------

// File: rtl/alu_uop_issue.sv
// alu_uop_issue: single-issue micro-op sequencer in front of an external
// combinational ALU. Holds the register file and the status register, reads
// operands on accept, presents them for one EXEC and one WB cycle, then
// writes the ALU result back according to the opcode class.
module alu_uop_issue #(
    parameter int NREG = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [3:0]  req_rn,
    input  logic [3:0]  req_rm,
    input  logic        req_useimm,
    input  logic [31:0] req_imm,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_sri,
    input  logic [31:0] alu_dst,
    input  logic [3:0]  alu_sro,
    output logic [3:0]  sr,
    output logic        done,
    output logic        err,
    input  logic [3:0]  dbg_idx,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] srca_q, srca_d;
    logic [31:0] srcb_q, srcb_d;
    logic [3:0]  sri_q, sri_d;
    logic [3:0]  sr_q, sr_d;
    logic        err_q, err_d;
    logic [31:0] regs_q [NREG];
    logic [31:0] regs_d [NREG];

    logic wr_reg, wr_sr, illegal;

    // Opcode classes for writeback; op 0x00 falls in none of them.
    assign wr_reg  = op_q inside {[5'h01:5'h09], [5'h14:5'h17]};
    assign wr_sr   = wr_reg || (op_q inside {5'h18, [5'h1B:5'h1F]});
    assign illegal = op_q inside {[5'h0A:5'h13], 5'h19, 5'h1A};

    // Next-state, operand capture on accept, and writeback on leaving WB.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rn_d    = rn_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        sri_d   = sri_q;
        sr_d    = sr_q;
        err_d   = err_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = EXEC;
                    op_d    = req_op;
                    rn_d    = req_rn;
                    // Both sources read the pre-writeback file, so rn==rm is safe.
                    srca_d  = regs_q[req_rn];
                    srcb_d  = req_useimm ? req_imm : regs_q[req_rm];
                    sri_d   = sr_q;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                state_d = IDLE;
                if (wr_reg)  regs_d[rn_q] = alu_dst;
                if (wr_sr)   sr_d = alu_sro;
                if (illegal) err_d = 1'b1;
                // ALU-facing outputs return to zero while idle.
                op_d   = '0;
                rn_d   = '0;
                srca_d = '0;
                srcb_d = '0;
                sri_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any micro-op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rn_q    <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            sri_q   <= '0;
            sr_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rn_q    <= rn_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            sri_q   <= sri_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == WB);
    assign alu_op    = op_q;
    assign alu_srca  = srca_q;
    assign alu_srcb  = srcb_q;
    assign alu_sri   = sri_q;
    assign sr        = sr_q;
    assign err       = err_q;
    assign dbg_data  = regs_q[dbg_idx];

endmodule

// File: tb/tb_alu_uop_issue.sv
// Bench for alu_uop_issue: a stand-in combinational ALU, a transaction-level
// model of the architectural state, a per-cycle compare process, and
// directed scenarios with literal expectations.
module tb_alu_uop_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [3:0]  req_rn = '0;
    logic [3:0]  req_rm = '0;
    logic        req_useimm = 1'b0;
    logic [31:0] req_imm = '0;
    logic [4:0]  alu_op;
    logic [31:0] alu_srca, alu_srcb, alu_dst;
    logic [3:0]  alu_sri, alu_sro;
    logic [3:0]  sr;
    logic        done, err;
    logic [3:0]  dbg_idx = '0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;
    logic [3:0] last_sri;

    always #5 clk = ~clk;

    alu_uop_issue #(.NREG(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rn(req_rn), .req_rm(req_rm), .req_useimm(req_useimm), .req_imm(req_imm),
        .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_sri(alu_sri),
        .alu_dst(alu_dst), .alu_sro(alu_sro),
        .sr(sr), .done(done), .err(err),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    // Stand-in ALU; returns {sro, dst}. Undefined ops produce loud garbage.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] s);
        logic [32:0] w;
        logic [31:0] d;
        logic [3:0]  o;
        d = a ^ b ^ 32'h1;
        o = s;
        case (op)
            5'h01: d = a + b;
            5'h02: d = a - b;
            5'h03: d = a & b;
            5'h04: d = a | b;
            5'h05: d = a ^ b;
            5'h06: d = b;
            5'h07: d = ~b;
            5'h08: d = a << b[4:0];
            5'h09: d = a >> b[4:0];
            5'h14: begin w = {1'b0, a} + {1'b0, b} + {32'b0, s[0]}; d = w[31:0]; o = {s[3:1], w[32]}; end
            5'h15: begin w = {1'b0, a} - {1'b0, b} - {32'b0, s[0]}; d = w[31:0]; o = {s[3:1], w[32]}; end
            5'h16, 5'h17: begin d = a + b; o = s ^ 4'h2; end
            5'h18: o = b[3:0];
            5'h1B: o = {s[3:1], a == b};
            5'h1C: o = {s[3:1], a > b};
            5'h1D, 5'h1E, 5'h1F: o = s ^ 4'h4;
            default: begin d = 32'hDEAD_BEEF; o = 4'hF; end
        endcase
        return {o, d};
    endfunction

    always_comb {alu_sro, alu_dst} = alu_fn(alu_op, alu_srca, alu_srcb, alu_sri);

    // Model: architectural registers plus the one micro-op in flight, tracked
    // by its age in cycles since acceptance (-1 = nothing in flight).
    logic [31:0] mregs [16];
    logic [3:0]  msr, mrn, msri, m_o;
    logic        merr;
    logic [4:0]  mop;
    logic [31:0] ma, mb, m_d;
    int          age = -1;
    int          cyc = 0;

    assign {m_o, m_d} = alu_fn(mop, ma, mb, msri);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mregs[i] <= '0;
            msr <= '0; merr <= 1'b0; age <= -1;
            mop <= '0; mrn <= '0; msri <= '0; ma <= '0; mb <= '0;
        end else begin
            cyc <= cyc + 1;
            if (age == 1) begin
                if (mop inside {[5'h01:5'h09], [5'h14:5'h17]}) begin
                    mregs[mrn] <= m_d;
                    msr <= m_o;
                end else if (mop inside {5'h18, [5'h1B:5'h1F]}) begin
                    msr <= m_o;
                end else if (mop != 5'h00) begin
                    merr <= 1'b1;
                end
                age <= -1;
            end else if (age == 0) begin
                age <= 1;
            end else if (req_valid) begin
                mop <= req_op; mrn <= req_rn; msri <= msr;
                ma <= mregs[req_rn];
                mb <= req_useimm ? req_imm : mregs[req_rm];
                age <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, age == -1});
            chk("done", {31'b0, done}, {31'b0, age == 1});
            chk("alu_op", {27'b0, alu_op}, (age >= 0) ? {27'b0, mop} : 32'h0);
            chk("alu_srca", alu_srca, (age >= 0) ? ma : 32'h0);
            chk("alu_srcb", alu_srcb, (age >= 0) ? mb : 32'h0);
            chk("alu_sri", {28'b0, alu_sri}, (age >= 0) ? {28'b0, msri} : 32'h0);
            chk("sr", {28'b0, sr}, {28'b0, msr});
            chk("err", {31'b0, err}, {31'b0, merr});
            chk("dbg_data", dbg_data, mregs[dbg_idx]);
        end
    end

    // Offer one micro-op, wait for accept, and pin the accept->done latency.
    // Called and returns at posedge+1.
    task automatic issue(input logic [4:0] op, input logic [3:0] rn, input logic [3:0] rm,
                         input logic ui, input logic [31:0] imm);
        int n = 0;
        req_op = op; req_rn = rn; req_rm = rm; req_useimm = ui; req_imm = imm;
        req_valid = 1'b1;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("accept", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("exec_no_done", {31'b0, done}, 32'h0);
        last_sri = alu_sri;
        @(negedge clk);
        chk("wb_done", {31'b0, done}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string nm);
        dbg_idx = idx;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        int a, b, n;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_sr", {28'b0, sr}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_alu_srca", alu_srca, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;

        // R1=5, R2=7, R1 += R2
        issue(5'h06, 4'd1, 4'd0, 1'b1, 32'd5);
        issue(5'h06, 4'd2, 4'd0, 1'b1, 32'd7);
        issue(5'h01, 4'd1, 4'd2, 1'b0, 32'd0);
        rd(4'd1, 32'd12, "r1_add");
        rd(4'd2, 32'd7, "r2_keep");

        // add-with-carry wraps to zero, carry into T
        issue(5'h06, 4'd3, 4'd0, 1'b1, 32'hFFFF_FFFF);
        issue(5'h18, 4'd0, 4'd0, 1'b1, 32'h1);
        chk("sr_load", {28'b0, sr}, 32'h1);
        issue(5'h14, 4'd3, 4'd0, 1'b1, 32'h0);
        chk("addc_sri", {28'b0, last_sri}, 32'h1);
        rd(4'd3, 32'h0, "r3_addc");
        chk("addc_sr", {28'b0, sr}, 32'h1);

        // compare updates only sr
        issue(5'h06, 4'd4, 4'd0, 1'b1, 32'd9);
        issue(5'h1B, 4'd4, 4'd0, 1'b1, 32'd9);
        chk("cmp_eq_t", {31'b0, sr[0]}, 32'h1);
        rd(4'd4, 32'd9, "r4_cmp_eq");
        issue(5'h1B, 4'd4, 4'd0, 1'b1, 32'd8);
        chk("cmp_ne_t", {31'b0, sr[0]}, 32'h0);
        rd(4'd4, 32'd9, "r4_cmp_ne");

        // back-to-back with req_valid held: R2=7+12=19, then R1=12+19=31
        req_op = 5'h01; req_rn = 4'd2; req_rm = 4'd1; req_useimm = 1'b0; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        a = cyc;
        req_rn = 4'd1; req_rm = 4'd2;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_accept", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
        b = cyc;
        req_valid = 1'b0;
        chk("b2b_gap", b - a, 32'd3);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rd(4'd2, 32'd19, "b2b_first");
        rd(4'd1, 32'd31, "b2b_second");

        // illegal op: no state change, sticky err
        issue(5'h18, 4'd0, 4'd0, 1'b1, 32'h6);
        issue(5'h0C, 4'd1, 4'd2, 1'b0, 32'h0);
        chk("illegal_err", {31'b0, err}, 32'h1);
        chk("illegal_sr", {28'b0, sr}, 32'h6);
        rd(4'd1, 32'd31, "illegal_r1");
        issue(5'h05, 4'd7, 4'd0, 1'b1, 32'h55);
        rd(4'd7, 32'h55, "xor_r7");
        issue(5'h00, 4'd7, 4'd0, 1'b1, 32'h1234);
        rd(4'd7, 32'h55, "nop_r7");
        issue(5'h01, 4'd7, 4'd7, 1'b0, 32'h0);
        rd(4'd7, 32'hAA, "rn_eq_rm");
        chk("err_sticky", {31'b0, err}, 32'h1);

        // reset during EXEC aborts with no done
        req_op = 5'h01; req_rn = 4'd1; req_rm = 4'd2; req_useimm = 1'b0; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_sr", {28'b0, sr}, 32'h0);
        chk("abort_err", {31'b0, err}, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rd(i[3:0], 32'h0, "abort_reg");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
